// File: rtl/upower_multicycle_sequencer.sv
// Multi-cycle control sequencer for the shared 64-bit uPOWER datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB per instruction and drives all datapath strobes.
module upower_multicycle_sequencer #(
  parameter int unsigned OP_LD   = 58,
  parameter int unsigned OP_STD  = 62,
  parameter int unsigned OP_BEQ  = 19,
  parameter int unsigned OP_BNE  = 20,
  parameter int unsigned OP_XO   = 31,
  parameter int unsigned OP_ADDI = 14,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero_flag,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_BR,
    CL_LD,
    CL_ST,
    CL_STOP,
    CL_ILL
  } class_t;

  state_t           cur_state, nxt_state;
  class_t           ir_class, fetch_class;
  logic [5:0]       ir_op;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic [31:0]      op_w;

  // Instruction class is resolved at fetch so DECODE does not depend on instr staying valid.
  always_comb begin
    op_w        = {26'b0, instr[31:26]};
    fetch_class = CL_ILL;
    if (instr == '1)
      fetch_class = CL_STOP;
    else if (op_w == OP_BEQ || op_w == OP_BNE)
      fetch_class = CL_BR;
    else if (op_w == OP_LD)
      fetch_class = CL_LD;
    else if (op_w == OP_STD)
      fetch_class = CL_ST;
    else if (op_w == OP_XO || (op_w >= OP_ADDI && op_w <= OP_ADDI + 32'd15))
      fetch_class = CL_ALU;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FETCH;
      ir_op     <= '0;
      ir_class  <= CL_ALU;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      cur_state <= nxt_state;
      if (ir_write) begin
        ir_op    <= instr[31:26];
        ir_class <= fetch_class;
      end
      if (cur_state == DECODE && ir_class == CL_ILL)
        illegal_q <= 1'b1;
      if (pc_write)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      FETCH:  if (imem_ack) nxt_state = DECODE;
      DECODE: nxt_state = (ir_class == CL_STOP || ir_class == CL_ILL) ? HALT : EXEC;
      EXEC: begin
        unique case (ir_class)
          CL_BR:        nxt_state = FETCH;
          CL_LD, CL_ST: nxt_state = MEM;
          default:      nxt_state = WB;
        endcase
      end
      MEM:    if (dmem_ack) nxt_state = (ir_class == CL_LD) ? WB : FETCH;
      WB:     nxt_state = FETCH;
      HALT:   nxt_state = HALT;
      default: nxt_state = FETCH;
    endcase
  end

  // Strobes are forced low while rst is high so an ack coinciding with reset has no effect.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    if (!rst) begin
      unique case (cur_state)
        FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ack;
        end
        EXEC: begin
          if (ir_class == CL_BR) begin
            pc_write = 1'b1;
            pc_src   = ({26'b0, ir_op} == OP_BEQ) ? zero_flag : ~zero_flag;
          end
        end
        MEM: begin
          dmem_req  = 1'b1;
          mem_read  = (ir_class == CL_LD);
          mem_write = (ir_class == CL_ST);
          pc_write  = (ir_class == CL_ST) && dmem_ack;
        end
        WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = cur_state;
  assign halted  = (cur_state == HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_upower_multicycle_sequencer.sv
// Directed bench for upower_multicycle_sequencer: walks each instruction class cycle by cycle
// and compares state, packed strobes, retired count and halt flags against hand-computed values.
module tb_upower_multicycle_sequencer;

  localparam int unsigned CNT_W = 32;

  // Packed strobe bits: {imem_req,dmem_req,mem_read,mem_write,ir_write,reg_write,pc_write,pc_src}
  localparam logic [7:0] S_IREQ = 8'h80;
  localparam logic [7:0] S_DREQ = 8'h40;
  localparam logic [7:0] S_RD   = 8'h20;
  localparam logic [7:0] S_WR   = 8'h10;
  localparam logic [7:0] S_IRW  = 8'h08;
  localparam logic [7:0] S_RW   = 8'h04;
  localparam logic [7:0] S_PCW  = 8'h02;
  localparam logic [7:0] S_PCS  = 8'h01;

  localparam logic [31:0] I_ADD  = {6'd31, 26'h0000123};
  localparam logic [31:0] I_LD   = {6'd58, 26'h0000040};
  localparam logic [31:0] I_STD  = {6'd62, 26'h0000080};
  localparam logic [31:0] I_BEQ  = {6'd19, 26'h0000010};
  localparam logic [31:0] I_BNE  = {6'd20, 26'h0000010};
  localparam logic [31:0] I_STOP = 32'hFFFF_FFFF;
  localparam logic [31:0] I_BAD  = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      instr = '0;
  logic             zero_flag = 1'b0;
  logic             imem_ack = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             imem_req, dmem_req, mem_read, mem_write;
  logic             ir_write, reg_write, pc_write, pc_src;
  logic             halted, illegal;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;
  logic [7:0]       strobes;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  upower_multicycle_sequencer #(
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .zero_flag (zero_flag),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .reg_write (reg_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired),
    .state     (state)
  );

  assign strobes = {imem_req, dmem_req, mem_read, mem_write, ir_write, reg_write, pc_write, pc_src};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare the settled outputs.
  task automatic step(input string tag, input logic [31:0] i, input logic ia, input logic da,
                      input logic zf, input logic r, input logic [2:0] exp_state,
                      input logic [7:0] exp_strobes);
    @(negedge clk);
    instr     = i;
    imem_ack  = ia;
    dmem_ack  = da;
    zero_flag = zf;
    rst       = r;
    #1;
    check({tag, ".state"}, 64'(state), 64'(exp_state));
    check({tag, ".strobes"}, 64'(strobes), 64'(exp_strobes));
  endtask

  initial begin
    // Reset held two cycles with an instruction ack present
    step("rst0", I_ADD, 1, 1, 0, 1, 3'd0, 8'h00);
    step("rst1", I_ADD, 1, 1, 0, 1, 3'd0, 8'h00);
    check("rst.retired", 64'(retired), 64'd0);
    check("rst.halted", 64'(halted), 64'd0);
    check("rst.illegal", 64'(illegal), 64'd0);

    // add: FETCH(ack) DECODE EXEC WB
    step("add.f", I_ADD, 1, 0, 0, 0, 3'd0, S_IREQ | S_IRW);
    step("add.d", '0, 0, 0, 0, 0, 3'd1, 8'h00);
    step("add.e", '0, 0, 0, 0, 0, 3'd2, 8'h00);
    step("add.w", '0, 0, 0, 0, 0, 3'd4, S_RW | S_PCW);
    check("add.ret_wb", 64'(retired), 64'd0);

    // ld with dmem_ack on the 4th MEM cycle; stray dmem_ack in FETCH/DECODE ignored
    step("ld.f", I_LD, 1, 1, 0, 0, 3'd0, S_IREQ | S_IRW);
    check("add.retired", 64'(retired), 64'd1);
    step("ld.d", '0, 0, 1, 0, 0, 3'd1, 8'h00);
    step("ld.e", '0, 0, 0, 0, 0, 3'd2, 8'h00);
    step("ld.m0", '0, 0, 0, 0, 0, 3'd3, S_DREQ | S_RD);
    step("ld.m1", '0, 0, 0, 0, 0, 3'd3, S_DREQ | S_RD);
    step("ld.m2", '0, 0, 0, 0, 0, 3'd3, S_DREQ | S_RD);
    step("ld.m3", '0, 0, 1, 0, 0, 3'd3, S_DREQ | S_RD);
    step("ld.w", '0, 0, 0, 0, 0, 3'd4, S_RW | S_PCW);

    // std with zero-wait ack retires from MEM
    step("st.f", I_STD, 1, 0, 0, 0, 3'd0, S_IREQ | S_IRW);
    check("ld.retired", 64'(retired), 64'd2);
    step("st.d", '0, 0, 0, 0, 0, 3'd1, 8'h00);
    step("st.e", '0, 0, 0, 0, 0, 3'd2, 8'h00);
    step("st.m", '0, 0, 1, 0, 0, 3'd3, S_DREQ | S_WR | S_PCW);

    // beq taken, then bne not taken, both with zero_flag=1
    step("beq.f", I_BEQ, 1, 0, 1, 0, 3'd0, S_IREQ | S_IRW);
    check("st.retired", 64'(retired), 64'd3);
    step("beq.d", '0, 0, 0, 1, 0, 3'd1, 8'h00);
    step("beq.e", '0, 0, 0, 1, 0, 3'd2, S_PCW | S_PCS);
    step("bne.f", I_BNE, 1, 0, 1, 0, 3'd0, S_IREQ | S_IRW);
    check("beq.retired", 64'(retired), 64'd4);
    step("bne.d", '0, 0, 0, 1, 0, 3'd1, 8'h00);
    step("bne.e", '0, 0, 0, 1, 0, 3'd2, S_PCW);
    step("idle", '0, 0, 0, 0, 0, 3'd0, S_IREQ);
    check("bne.retired", 64'(retired), 64'd5);

    // Reset, then std with rst asserted on the dmem_ack cycle
    step("rst2", '0, 0, 0, 0, 1, 3'd0, 8'h00);
    step("str.f", I_STD, 1, 0, 0, 0, 3'd0, S_IREQ | S_IRW);
    step("str.d", '0, 0, 0, 0, 0, 3'd1, 8'h00);
    step("str.e", '0, 0, 0, 0, 0, 3'd2, 8'h00);
    step("str.m0", '0, 0, 0, 0, 0, 3'd3, S_DREQ | S_WR);
    step("str.m1", '0, 0, 1, 0, 1, 3'd3, 8'h00);
    step("str.after", '0, 0, 0, 0, 0, 3'd0, S_IREQ);
    check("str.retired", 64'(retired), 64'd0);

    // All-ones instruction halts cleanly; later acks ignored
    step("stop.f", I_STOP, 1, 0, 0, 0, 3'd0, S_IREQ | S_IRW);
    step("stop.d", '0, 0, 0, 0, 0, 3'd1, 8'h00);
    step("stop.h", I_ADD, 1, 1, 0, 0, 3'd5, 8'h00);
    step("stop.h2", I_ADD, 1, 1, 0, 0, 3'd5, 8'h00);
    check("stop.halted", 64'(halted), 64'd1);
    check("stop.illegal", 64'(illegal), 64'd0);

    // Opcode 0 halts as illegal
    step("rst3", '0, 0, 0, 0, 1, 3'd5, 8'h00);
    step("bad.f", I_BAD, 1, 0, 0, 0, 3'd0, S_IREQ | S_IRW);
    check("bad.halted0", 64'(halted), 64'd0);
    step("bad.d", '0, 0, 0, 0, 0, 3'd1, 8'h00);
    step("bad.h", '0, 1, 0, 0, 0, 3'd5, 8'h00);
    check("bad.halted", 64'(halted), 64'd1);
    check("bad.illegal", 64'(illegal), 64'd1);
    check("bad.retired", 64'(retired), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
